// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the TinyCPU instruction sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {HOST, FETCH, EXEC, JMPA, JMPD} seq_state_e;

  localparam logic [7:0] IDLE_INSTR = 8'hF0;
  localparam logic [5:0] JMP_PFX    = 6'b1111_01;
  localparam logic [5:0] MEM_PFX    = 6'b1111_11;
  localparam logic [5:0] RSV_PFX    = 6'b1111_10;

  localparam logic [1:0] CC_ALW  = 2'b00;
  localparam logic [1:0] CC_Z    = 2'b01;
  localparam logic [1:0] CC_NZ   = 2'b10;
  localparam logic [1:0] CC_HALT = 2'b11;

  typedef struct packed {
    logic       is_issue;
    logic       is_alu;
    logic       is_jmp;
    logic       is_mem;
    logic       is_rsv;
    logic [1:0] cc;
  } instr_dec_t;

  // ALU-class instructions are the only ones that update the zero flag
  function automatic logic is_alu_class(logic [7:0] instr);
    return (instr[7:6] != 2'b10) && (instr[7:4] != 4'hF);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Host instruction stream and instruction-memory read port of the sequencer.
interface cpu_sequencer_if #(
  parameter int unsigned WORDSIZE = 8,
  parameter int unsigned PC_BITS  = 4
) ();
  logic [WORDSIZE-1:0] host_instr;
  logic                host_valid;
  logic                host_ready;
  logic [PC_BITS-1:0]  imem_addr;
  logic [WORDSIZE-1:0] imem_data;

  // Host and memory side
  modport master (
    output host_instr, host_valid, imem_data,
    input  host_ready, imem_addr
  );

  // Sequencer side
  modport slave (
    input  host_instr, host_valid, imem_data,
    output host_ready, imem_addr
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational classifier for one instruction byte.
module seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [7:0] instr,
  output instr_dec_t dec
);

  // Classify by prefix; anything not special is issued to the CPU
  always_comb begin
    dec          = '0;
    dec.is_jmp   = (instr[7:2] == JMP_PFX);
    dec.is_mem   = (instr[7:2] == MEM_PFX);
    dec.is_rsv   = (instr[7:2] == RSV_PFX);
    dec.is_alu   = is_alu_class(instr);
    dec.cc       = instr[1:0];
    dec.is_issue = !(dec.is_jmp || dec.is_mem || dec.is_rsv || (instr == IDLE_INSTR));
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Feeds the TinyCPU one instruction at a time from the host stream or from
// instruction memory, and executes jump/halt/memory-mode opcodes itself.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned WORDSIZE = 8,
  parameter int unsigned PC_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  cpu_sequencer_if.slave      bus,
  input  logic                cpu_zf,
  output logic [WORDSIZE-1:0] cpu_instr,
  output logic [PC_BITS-1:0]  pc,
  output logic                mem_mode,
  output logic                done
);

  seq_state_e          state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [WORDSIZE-1:0] cpu_instr_q, cpu_instr_d;
  logic                alu_q, alu_d;   // cpu_instr_q is ALU class
  logic                zf_q;
  logic [1:0]          cc_q, cc_d;
  logic                done_q, done_d;
  logic                take;

  instr_dec_t host_dec, imem_dec, dec;

  seq_decode u_host_dec (
    .instr (bus.host_instr),
    .dec   (host_dec)
  );

  seq_decode u_imem_dec (
    .instr (bus.imem_data),
    .dec   (imem_dec)
  );

  // Only HOST looks at the host byte; EXEC is the only other state that decodes
  assign dec = (state_q == HOST) ? host_dec : imem_dec;

  assign take = (cc_q == CC_ALW) || ((cc_q == CC_Z) && zf_q) || ((cc_q == CC_NZ) && !zf_q);

  // Next-state, pc and issue logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cpu_instr_d = IDLE_INSTR;
    alu_d       = 1'b0;
    cc_d        = cc_q;
    done_d      = 1'b0;
    case (state_q)
      HOST: begin
        if (bus.host_valid) begin
          if (dec.is_mem) begin
            pc_d    = '0;
            state_d = FETCH;
          end else if (dec.is_issue) begin
            cpu_instr_d = bus.host_instr;
            alu_d       = dec.is_alu;
          end
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (dec.is_issue) begin
          cpu_instr_d = bus.imem_data;
          alu_d       = dec.is_alu;
          pc_d        = pc_q + PC_BITS'(1);
          state_d     = FETCH;
        end else if (dec.is_jmp) begin
          if (dec.cc == CC_HALT) begin
            done_d  = 1'b1;
            state_d = HOST;
          end else begin
            cc_d    = dec.cc;
            state_d = JMPA;
          end
        end else if (dec.is_rsv || dec.is_mem) begin
          pc_d    = pc_q + PC_BITS'(1);
          state_d = FETCH;
        end else begin
          // Idle word in memory: step over it
          pc_d    = pc_q + PC_BITS'(1);
          state_d = FETCH;
        end
      end
      JMPA: state_d = JMPD;
      JMPD: begin
        pc_d    = take ? bus.imem_data[PC_BITS-1:0] : pc_q + PC_BITS'(2);
        state_d = FETCH;
      end
      default: state_d = HOST;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOST;
      pc_q        <= '0;
      cpu_instr_q <= IDLE_INSTR;
      alu_q       <= 1'b0;
      zf_q        <= 1'b0;
      cc_q        <= CC_ALW;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cpu_instr_q <= cpu_instr_d;
      alu_q       <= alu_d;
      cc_q        <= cc_d;
      done_q      <= done_d;
      if (alu_q) zf_q <= cpu_zf;
    end
  end

  // Target byte sits right after the JMP opcode
  assign bus.imem_addr  = (state_q == JMPA) ? pc_q + PC_BITS'(1) : pc_q;
  assign bus.host_ready = (state_q == HOST);
  assign cpu_instr      = cpu_instr_q;
  assign pc             = pc_q;
  assign mem_mode       = (state_q != HOST);
  assign done           = done_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_zf;
  logic [7:0] cpu_instr;
  logic [3:0] pc;
  logic       mem_mode;
  logic       done;
  logic       zf_drive;

  logic [7:0] imem [16];
  logic [7:0] iss [$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cycles;
  logic       got_done;

  cpu_sequencer_if #(.WORDSIZE(8), .PC_BITS(4)) bus ();

  cpu_sequencer #(.WORDSIZE(8), .PC_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_zf    (cpu_zf),
    .cpu_instr (cpu_instr),
    .pc        (pc),
    .mem_mode  (mem_mode),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the address
  always @(posedge clk) bus.imem_data <= imem[bus.imem_addr];

  // Only the E0 ALU op reports the driven flag; every other instruction gives zero
  assign cpu_zf = (cpu_instr == 8'hE0) ? zf_drive : 1'b0;

  typedef struct {
    logic [7:0] instr;
    logic       valid;
    logic [7:0] exp_instr;
  } host_vec_t;

  host_vec_t hv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = 8'hF0;
  endtask

  // Send MEM from the host, then step until done or budget runs out
  task automatic run_prog(input int budget);
    bus.host_instr = 8'hFC;
    bus.host_valid = 1'b1;
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    bus.host_instr = 8'h00;
    iss.delete();
    cycles   = 0;
    got_done = 1'b0;
    while (!got_done && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (cpu_instr != 8'hF0) iss.push_back(cpu_instr);
      if (done) got_done = 1'b1;
    end
    check("done_seen", 32'(got_done), 32'd1);
  endtask

  task automatic check_done_state(input string tag, input int exp_cycles, input logic [3:0] exp_pc);
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_mem_mode"}, 32'(mem_mode), 32'd0);
    check({tag, "_host_ready"}, 32'(bus.host_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    zf_drive       = 1'b0;
    bus.host_instr = 8'h00;
    bus.host_valid = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cpu_instr", 32'(cpu_instr), 32'hF0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_host_ready", 32'(bus.host_ready), 32'd1);
    check("rst_mem_mode", 32'(mem_mode), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Host stream: back-to-back issues, gaps and non-issuable opcodes
    hv[0] = '{8'h93, 1'b1, 8'h93};
    hv[1] = '{8'h81, 1'b1, 8'h81};
    hv[2] = '{8'h00, 1'b0, 8'hF0};
    hv[3] = '{8'hF4, 1'b1, 8'hF0};
    hv[4] = '{8'hF0, 1'b1, 8'hF0};
    hv[5] = '{8'hF9, 1'b1, 8'hF0};
    hv[6] = '{8'h3C, 1'b0, 8'hF0};
    hv[7] = '{8'hF1, 1'b1, 8'hF1};
    for (int i = 0; i < 8; i++) begin
      bus.host_instr = hv[i].instr;
      bus.host_valid = hv[i].valid;
      @(posedge clk); #1;
      check($sformatf("host_vec%0d_instr", i), 32'(cpu_instr), 32'(hv[i].exp_instr));
      check($sformatf("host_vec%0d_ready", i), 32'(bus.host_ready), 32'd1);
    end
    bus.host_valid = 1'b0;
    @(posedge clk); #1;
    check("host_back_to_idle", 32'(cpu_instr), 32'hF0);

    // Straight-line program ending in halt at pc=2; accept cycle + 6 = 7 cycles
    clear_mem();
    imem[0] = 8'h85; imem[1] = 8'h04; imem[2] = 8'hF7; imem[3] = 8'h00;
    run_prog(20);
    check("p1_n_issued", iss.size(), 2);
    if (iss.size() == 2) begin
      check("p1_issue0", 32'(iss[0]), 32'h85);
      check("p1_issue1", 32'(iss[1]), 32'h04);
    end
    check_done_state("p1", 6, 4'd2);

    // Jump-if-zero taken: E0 sets the flag, jump to 4, halt
    clear_mem();
    imem[0] = 8'hE0; imem[1] = 8'hF5; imem[2] = 8'h04; imem[3] = 8'h00; imem[4] = 8'hF7;
    zf_drive = 1'b1;
    run_prog(20);
    check("jz_taken_n_issued", iss.size(), 1);
    if (iss.size() == 1) check("jz_taken_issue0", 32'(iss[0]), 32'hE0);
    check_done_state("jz_taken", 8, 4'd4);

    // Same program with zero flag clear: falls through to 3, issues 00, halts at 4
    zf_drive = 1'b0;
    run_prog(20);
    check("jz_fall_n_issued", iss.size(), 2);
    if (iss.size() == 2) begin
      check("jz_fall_issue0", 32'(iss[0]), 32'hE0);
      check("jz_fall_issue1", 32'(iss[1]), 32'h00);
    end
    check_done_state("jz_fall", 10, 4'd4);

    // JMP at 15 takes its target from address 0 (F4 -> pc 4)
    clear_mem();
    imem[0] = 8'hF4; imem[1] = 8'h0E; imem[4] = 8'hF7; imem[14] = 8'h85; imem[15] = 8'hF4;
    run_prog(30);
    check("wrapjmp_n_issued", iss.size(), 1);
    if (iss.size() == 1) check("wrapjmp_issue0", 32'(iss[0]), 32'h85);
    check_done_state("wrapjmp", 12, 4'd4);

    // Plain instruction at 15 wraps the fetch to 0, then reset lands mid-JMPA
    clear_mem();
    imem[0] = 8'hF4; imem[1] = 8'h0F; imem[15] = 8'h85;
    bus.host_instr = 8'hFC;
    bus.host_valid = 1'b1;
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("wrap_issue", 32'(cpu_instr), 32'h85);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_fetch_addr", 32'(bus.imem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("jmpa_addr", 32'(bus.imem_addr), 32'd1);
    check("jmpa_mem_mode", 32'(mem_mode), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_cpu_instr", 32'(cpu_instr), 32'hF0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_host_ready", 32'(bus.host_ready), 32'd1);
    check("midrst_mem_mode", 32'(mem_mode), 32'd0);
    @(posedge clk); #1;
    check("midrst_stays_host", 32'(mem_mode), 32'd0);
    check("midrst_stays_idle", 32'(cpu_instr), 32'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the 8-bit TinyCPU datapath. Feeds the CPU's `instr` input one instruction at a time, either from a host valid/ready stream (host mode) or from a small instruction memory via a program counter (memory mode). Implements the opcodes the CPU's control unit leaves unimplemented: conditional/unconditional jump, halt and the memory-mode switch. Keeps the CPU on a non-writing idle instruction whenever nothing is issued.

## Interface
- `WORDSIZE`, 8: CPU word width; also the instruction width.
- `PC_BITS`, 4: program counter width (instruction memory depth 2^PC_BITS).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `host_instr` input 8: host instruction.
- `host_valid` input 1: host instruction present.
- `host_ready` output 1: sequencer accepts a host instruction this cycle.
- `imem_addr` output PC_BITS: instruction memory read address (combinational from state/pc).
- `imem_data` input 8: memory read data, valid 1 cycle after `imem_addr` is presented.
- `cpu_zf` input 1: ALU zero flag from the CPU, combinational on the current `cpu_instr`.
- `cpu_instr` output 8: registered instruction driven into the CPU.
- `pc` output PC_BITS: current program counter.
- `mem_mode` output 1: 1 while executing from memory.
- `done` output 1: one-cycle pulse when a memory program halts.

## Operation
- Instruction classes, by `instr[7:0]`:
  - IDLE = 8'hF0 (read r0, no register write).
  - JMP = 1111_01cc. cc=00 always; 01 if zf_q=1; 10 if zf_q=0; 11 halt. Two-byte: the target byte follows at pc+1, and `target[PC_BITS-1:0]` is used.
  - MEM = 1111_11xx, host mode only: enter memory mode at pc=0. Not issued to the CPU.
  - RSV = 1111_10xx: never issued. Treated as a 1-byte NOP.
  - All others are issued to the CPU.
  - ALU class = `instr[7:6]!=2'b10` and `instr[7:4]!=4'hF`.
- States:
  - HOST: `host_ready=1`. On `host_valid`:
    - MEM → pc=0, go to FETCH.
    - JMP/RSV/IDLE from host → discarded (no issue).
    - Otherwise → `cpu_instr<=host_instr`.
  - FETCH: `imem_addr=pc` → EXEC.
  - EXEC: decode `imem_data`.
    - Issuable → `cpu_instr<=imem_data`, pc<=pc+1, → FETCH.
    - RSV or MEM → pc+1, → FETCH.
    - JMP cc≠11 → JMPA.
    - JMP cc=11 → `done` pulse, pc unchanged, → HOST.
  - JMPA: `imem_addr=pc+1` → JMPD.
  - JMPD: if the condition holds, pc<=`imem_data[PC_BITS-1:0]`; else pc<=pc+2. → FETCH.
- `cpu_instr` holds an issued instruction for exactly one cycle, then returns to IDLE.
- zf_q: on the cycle `cpu_instr` holds an ALU-class instruction, zf_q<=`cpu_zf`. Otherwise it holds.
- pc arithmetic is modulo 2^PC_BITS: pc+1 and pc+2 wrap silently.
- `host_valid` is ignored outside HOST; the host must hold its instruction until `host_ready`.
- There is no exit from memory mode other than halt or `rst`. A program with no halt runs forever.

## Timing
- Reset values: state=HOST, pc=0, zf_q=0, `cpu_instr`=8'hF0, `done`=0, `mem_mode`=0. `host_ready` is 1 from the first cycle after reset.
- `rst` mid-operation aborts immediately. Any pending jump or issue is dropped, and `cpu_instr` returns to IDLE on the next cycle.
- Host issue: accepted at edge N, `cpu_instr` valid during cycle N→N+1, CPU register write at edge N+1. Host throughput is one per cycle.
- Memory mode: 2 cycles per plain instruction; 4 cycles per jump (FETCH, EXEC, JMPA, JMPD).
- Flag timing: zf_q updates at the end of the issue cycle, so a JMP immediately following an ALU op observes that op's flag.
- `done` is asserted in the cycle after the halt EXEC, with `mem_mode`=0 and `host_ready`=1 in that same cycle.

## Structure
- Package `cpu_seq_pkg` contains:
  - The state enum: HOST, FETCH, EXEC, JMPA, JMPD.
  - Constants IDLE_INSTR=8'hF0, JMP_PFX=6'b1111_01, MEM_PFX=6'b1111_11, RSV_PFX=6'b1111_10.
  - cc codes CC_ALW, CC_Z, CC_NZ, CC_HALT.
- Sub-module `seq_decode` (combinational): classifies an instruction byte into is_issue/is_alu/is_jmp/is_mem/is_rsv plus cc. Instantiated once for `host_instr` and once for `imem_data`.

## Test plan
- Reset: hold `rst` for 2 cycles mid-JMPA. Required afterwards: `cpu_instr`=F0, pc=0, `host_ready`=1, `mem_mode`=0.
- Host stream: send 8'h93 (write -3 to r1), then 8'h81, back-to-back. Required: `cpu_instr`=93 then 81 on consecutive cycles, then F0. A host-sent 8'hF4 is never issued.
- Memory program at addresses 0..3 = {8'h85, 8'h04, 8'hF7, 8'h00}, entered via host 8'hFC.
  - Required: issues 85, then 04 (r0+r1).
  - JMP halt at pc=2 pulses `done` with pc=2.
  - Total 7 cycles from the MEM accept edge to `done`.
- Conditional jump, at addresses 0..4 = {8'hE0, 8'hF5, 8'h04, 8'h00, 8'hF7}.
  - 8'hE0 is an ALU op whose `cpu_zf` is driven to 1; the following jump-if-zero then jumps to 4 and halts.
  - Repeat with `cpu_zf`=0: the jump falls through to pc=3.
- Wrap: with PC_BITS=4, a plain instruction at address 15 → next fetch at `imem_addr`=0. A JMP at address 15 reads its target from address 0.
